b1_scfifo_reader: RTL



---
 rtl/b1_fifo_pkg.sv | 10 +
 rtl/b1_skid_buf2.sv | 47 ++++
 rtl/b1_scfifo_reader.sv | 65 ++++++
 3 files changed

// File: rtl/b1_fifo_pkg.sv
// Shared definitions for the single-clock FIFO family and its read-side adapters.
package b1_fifo_pkg;

    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned LVL_W     = 2;

    typedef logic [LVL_W-1:0] lvl_t;

endpackage : b1_fifo_pkg

// File: rtl/b1_skid_buf2.sv
// Two-entry registered buffer with independent head/tail pointers and an occupancy count.
module b1_skid_buf2
    import b1_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic [1:0]        cnt
);

    logic [DWIDTH-1:0] r_mem [BUF_DEPTH];
    logic              r_head;
    logic              r_tail;
    lvl_t              r_cnt;

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            r_mem[r_tail] <= wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (wr_en) begin
                r_tail <= ~r_tail;
            end
            if (rd_en) begin
                r_head <= ~r_head;
            end
            r_cnt <= lvl_t'(r_cnt + lvl_t'(wr_en) - lvl_t'(rd_en));
        end
    end

    assign rd_data = r_mem[r_head];
    assign cnt     = r_cnt;

endmodule : b1_skid_buf2

// File: rtl/b1_scfifo_reader.sv
// Drains a non-showahead single-clock FIFO and re-presents its words as a
// zero-latency valid/ready stream, hiding the FIFO read latency in a 2-entry buffer.
module b1_scfifo_reader
    import b1_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [1:0]        level_o
);

    localparam int unsigned OCC_W = 3;

    logic [RD_LAT-1:0] r_inflight;
    lvl_t              w_cnt;
    logic              w_pop;
    logic              w_arrive;
    logic [OCC_W-1:0]  w_occ;

    assign w_arrive = r_inflight[RD_LAT-1];
    assign w_pop    = valid_o & ready_i;
    assign valid_o  = (w_cnt != '0);
    assign level_o  = w_cnt;

    // Projected occupancy after this cycle; the combinational ready_i path here is intentional.
    assign w_occ        = OCC_W'(w_cnt) + OCC_W'($countones(r_inflight)) - OCC_W'(w_pop);
    assign fifo_rdreq_o = !srst_i && !fifo_empty_i && (w_occ < OCC_W'(BUF_DEPTH));

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= RD_LAT'({r_inflight, fifo_rdreq_o});
        end
    end

    b1_skid_buf2 #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .wr_en   (w_arrive),
        .wr_data (fifo_q_i),
        .rd_en   (w_pop),
        .rd_data (data_o),
        .cnt     (w_cnt)
    );

    a_no_overflow: assert property (@(posedge clk_i) disable iff (srst_i)
        !(w_arrive && (w_cnt == lvl_t'(BUF_DEPTH)) && !w_pop));

    a_no_read_empty: assert property (@(posedge clk_i) disable iff (srst_i)
        !(fifo_rdreq_o && fifo_empty_i));

    a_hold_data: assert property (@(posedge clk_i) disable iff (srst_i)
        (valid_o && !ready_i) |=> $stable(data_o));

endmodule : b1_scfifo_reader
